// File: rtl/ethernet_udp_pkg.sv
// Shared Ethernet/IPv4/UDP constants, field offsets and receiver state encoding.
// Used by both the UDP request receiver and the reply transmitter.
package ethernet_udp_pkg;

  localparam int unsigned HEAD_BYTES     = 42;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
  localparam int unsigned UDP_HDR_BYTES  = 8;

  localparam int unsigned ETHERTYPE_OFF  = 12;
  localparam int unsigned IP_PROTO_OFF   = 23;
  localparam int unsigned UDP_DPORT_OFF  = 36;
  localparam int unsigned UDP_LEN_OFF    = 38;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEAD,
    ST_PAYLOAD,
    ST_PAD,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Big-endian 16-bit field at byte offset off; byte 0 sits at the vector MSB.
  function automatic logic [15:0] head_field16(input logic [HEAD_BYTES*8-1:0] h,
                                               input int unsigned off);
    return h[(HEAD_BYTES-off)*8-1 -: 16];
  endfunction

endpackage

// File: rtl/ethernet_udp_request_receiver_if.sv
// Byte-stream input and captured-frame outputs of the UDP request receiver.
interface ethernet_udp_request_receiver_if #(
  parameter int unsigned MAX_PAYLOAD = 63
);
  import ethernet_udp_pkg::*;

  logic [7:0]                o_unused_placeholder_never;
  logic [7:0]                i_word;
  logic                      i_valid;
  logic [HEAD_BYTES*8-1:0]   o_udp_request_head;
  logic [MAX_PAYLOAD*8-1:0]  o_udp_request_payload;
  logic [15:0]               o_udp_request_payload_size;
  logic                      o_udp_request_ready;
  logic                      o_udp_request_drop;

  modport master (
    output i_word, i_valid,
    input  o_udp_request_head, o_udp_request_payload, o_udp_request_payload_size,
    input  o_udp_request_ready, o_udp_request_drop
  );

  modport slave (
    input  i_word, i_valid,
    output o_udp_request_head, o_udp_request_payload, o_udp_request_payload_size,
    output o_udp_request_ready, o_udp_request_drop
  );

endinterface

// File: rtl/ethernet_udp_header_check.sv
// Combinational validation of the 42-byte Eth+IPv4+UDP header and payload size extraction.
// Optional UDP_REQUEST_RX_PORT_FILTER_EN also requires dst port == LOCAL_PORT.
module ethernet_udp_header_check
  import ethernet_udp_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD = 63,
  parameter logic [15:0] LOCAL_PORT  = 16'd5000
) (
  input  logic [HEAD_BYTES*8-1:0] head,
  output logic                    hdr_ok,
  output logic [15:0]             payload_size
);

  logic [15:0] ethertype_c;
  logic [15:0] udp_dport_c;
  logic [15:0] udp_len_c;
  logic [7:0]  ip_proto_c;
  logic        base_ok_c;
  logic        port_match_c;
  logic        unused_c;

  assign ethertype_c  = head_field16(head, ETHERTYPE_OFF);
  assign udp_dport_c  = head_field16(head, UDP_DPORT_OFF);
  assign udp_len_c    = head_field16(head, UDP_LEN_OFF);
  assign ip_proto_c   = head[(HEAD_BYTES-IP_PROTO_OFF)*8-1 -: 8];
  assign port_match_c = (udp_dport_c == LOCAL_PORT);

  // Length bounds expressed on udp_len directly so a short length cannot wrap.
  assign base_ok_c = (ethertype_c == ETHERTYPE_IPV4) &&
                     (ip_proto_c == IP_PROTO_UDP) &&
                     (udp_len_c >= 16'(UDP_HDR_BYTES)) &&
                     (udp_len_c <= 16'(MAX_PAYLOAD + UDP_HDR_BYTES));

`ifdef UDP_REQUEST_RX_PORT_FILTER_EN
  assign hdr_ok = base_ok_c && port_match_c;
`else
  assign hdr_ok = base_ok_c;
`endif

  assign payload_size = udp_len_c - 16'(UDP_HDR_BYTES);

  // Most header bytes are carried, not inspected.
  assign unused_c = ^{head, port_match_c};

endmodule

// File: rtl/ethernet_udp_request_receiver.sv
// Receives an 8-bit UDP request stream, validates it and presents head/payload/size.
// Build option UDP_REQUEST_RX_PORT_FILTER_EN enables destination-port filtering.
module ethernet_udp_request_receiver
  import ethernet_udp_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD = 63,
  parameter logic [15:0] LOCAL_PORT  = 16'd5000
) (
  input logic                            i_clk,
  input logic                            i_reset,
  ethernet_udp_request_receiver_if.slave bus
);

  localparam int unsigned HEAD_W = HEAD_BYTES * 8;
  localparam int unsigned PAY_W  = MAX_PAYLOAD * 8;
  localparam int unsigned CNT_W  = 8;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               reject_q, reject_d;
  logic [HEAD_W-1:0]  head_buf_q, head_buf_d;
  logic [PAY_W-1:0]   pay_buf_q, pay_buf_d;
  logic [15:0]        size_q, size_d;
  logic [HEAD_W-1:0]  head_out_q, head_out_d;
  logic [PAY_W-1:0]   pay_out_q, pay_out_d;
  logic [15:0]        size_out_q, size_out_d;
  logic               ready_q, ready_d;
  logic               drop_q, drop_d;

  logic [HEAD_W-1:0]  hdr_vec_c;
  logic [CNT_W-1:0]   cnt_inc_c;
  logic               hdr_ok;
  logic [15:0]        payload_size;
  logic               start_c;

  assign hdr_vec_c = {head_buf_q[HEAD_W-9:0], bus.i_word};
  assign cnt_inc_c = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  ethernet_udp_header_check #(
    .MAX_PAYLOAD (MAX_PAYLOAD),
    .LOCAL_PORT  (LOCAL_PORT)
  ) u_header_check (
    .head         (hdr_vec_c),
    .hdr_ok       (hdr_ok),
    .payload_size (payload_size)
  );

  // Next-state and capture logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    reject_d   = reject_q;
    head_buf_d = head_buf_q;
    pay_buf_d  = pay_buf_q;
    size_d     = size_q;
    head_out_d = head_out_q;
    pay_out_d  = pay_out_q;
    size_out_d = size_out_q;
    ready_d    = 1'b0;
    drop_d     = 1'b0;
    start_c    = 1'b0;

    case (state_q)
      ST_IDLE: start_c = bus.i_valid;

      ST_HEAD: begin
        if (bus.i_valid) begin
          head_buf_d = hdr_vec_c;
          cnt_d      = cnt_inc_c;
          if (cnt_q == CNT_W'(HEAD_BYTES - 1)) begin
            if (hdr_ok) begin
              size_d  = payload_size;
              cnt_d   = '0;
              state_d = (payload_size == 16'd0) ? ST_PAD : ST_PAYLOAD;
            end else begin
              reject_d = 1'b1;
              state_d  = ST_DRAIN;
            end
          end
        end else begin
          reject_d = 1'b1;
          state_d  = ST_DONE;
        end
      end

      ST_PAYLOAD: begin
        if (bus.i_valid) begin
          for (int unsigned b = 0; b < MAX_PAYLOAD; b++) begin
            if (cnt_q == CNT_W'(b)) pay_buf_d[PAY_W-1-8*b -: 8] = bus.i_word;
          end
          cnt_d = cnt_inc_c;
          if ((16'(cnt_q) + 16'd1) == size_q) state_d = ST_PAD;
        end else begin
          reject_d = 1'b1;
          state_d  = ST_DONE;
        end
      end

      ST_PAD: begin
        if (bus.i_valid) cnt_d = cnt_inc_c;
        else             state_d = ST_DONE;
      end

      // Rejected frames owe a drop pulse; frames cut by reset owe nothing.
      ST_DRAIN: begin
        if (!bus.i_valid) state_d = reject_q ? ST_DONE : ST_IDLE;
      end

      ST_DONE: begin
        if (reject_q) begin
          drop_d = 1'b1;
        end else begin
          head_out_d = head_buf_q;
          pay_out_d  = pay_buf_q;
          size_out_d = size_q;
          ready_d    = 1'b1;
        end
        state_d = ST_IDLE;
        start_c = bus.i_valid;
      end

      default: state_d = ST_IDLE;
    endcase

    // A byte seen in IDLE or DONE opens a new frame.
    if (start_c) begin
      head_buf_d = hdr_vec_c;
      pay_buf_d  = '0;
      cnt_d      = CNT_W'(1);
      reject_d   = 1'b0;
      state_d    = ST_HEAD;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= bus.i_valid ? ST_DRAIN : ST_IDLE;
      cnt_q      <= '0;
      reject_q   <= 1'b0;
      head_buf_q <= '0;
      pay_buf_q  <= '0;
      size_q     <= '0;
      head_out_q <= '0;
      pay_out_q  <= '0;
      size_out_q <= '0;
      ready_q    <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      reject_q   <= reject_d;
      head_buf_q <= head_buf_d;
      pay_buf_q  <= pay_buf_d;
      size_q     <= size_d;
      head_out_q <= head_out_d;
      pay_out_q  <= pay_out_d;
      size_out_q <= size_out_d;
      ready_q    <= ready_d;
      drop_q     <= drop_d;
    end
  end

  assign bus.o_udp_request_head         = head_out_q;
  assign bus.o_udp_request_payload      = pay_out_q;
  assign bus.o_udp_request_payload_size = size_out_q;
  assign bus.o_udp_request_ready        = ready_q;
  assign bus.o_udp_request_drop         = drop_q;

endmodule
